// File: rtl/clk_duty.sv
// Button-controlled PWM generator: four debounced-edge buttons adjust an 8-bit duty setting,
// clk is a frame-synchronous PWM at that duty, and the duty is shown on 7-segment digits.
module clk_duty #(
  parameter int unsigned PERIOD      = 100,
  parameter int unsigned RESET_DUTY  = 50,
  parameter int unsigned STEP_FINE   = 1,
  parameter int unsigned STEP_COARSE = 10
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       inc,
  input  logic       inc1,
  input  logic       dec,
  input  logic       dec1,
  output logic       clk,
  output logic [0:6] d0,
  output logic [0:6] d1,
  output logic [0:6] d2,
  output logic [0:6] d3,
  output logic [7:0] d
);

  localparam logic [7:0]        PeriodVal = 8'(PERIOD);
  localparam logic [7:0]        ResetVal  = 8'(RESET_DUTY);
  localparam logic [7:0]        LastCnt   = 8'(PERIOD - 1);
  localparam logic signed [9:0] PeriodS   = 10'(PERIOD);
  localparam logic signed [9:0] FineS     = 10'(STEP_FINE);
  localparam logic signed [9:0] CoarseS   = 10'(STEP_COARSE);
  localparam logic [1:0]        FillFull  = 2'd3;

  // Button vector in priority order: [0]=inc1, [1]=inc, [2]=dec1, [3]=dec
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] prev_q, prev_d;
  logic [1:0] fill_q, fill_d;
  logic [3:0] press;

  logic [7:0] d_q, d_d;
  logic [7:0] active_q, active_d;
  logic [7:0] cnt_q, cnt_d;
  logic       clk_q, clk_d;

  logic signed [9:0] step;
  logic signed [9:0] sum;

  logic [3:0] ones, tens, hund;

  assign btn_raw = {dec, dec1, inc, inc1};

  // prev_q holds a reset value until three real samples have passed through, so a button held
  // low across reset release is not mistaken for a fresh press.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    fill_d  = (fill_q == FillFull) ? fill_q : fill_q + 2'd1;
  end

  assign press = prev_q & ~sync2_q & {4{fill_q == FillFull}};

  always_comb begin
    step = '0;
    d_d  = d_q;
    if (press[0]) begin
      step = CoarseS;
    end else if (press[1]) begin
      step = FineS;
    end else if (press[2]) begin
      step = -CoarseS;
    end else if (press[3]) begin
      step = -FineS;
    end
    sum = $signed({2'b00, d_q}) + step;
    if (press != 4'b0000) begin
      if (sum > PeriodS) begin
        d_d = PeriodVal;
      end else if (sum < 0) begin
        d_d = '0;
      end else begin
        d_d = sum[7:0];
      end
    end
  end

  // Active duty only changes on the last cycle of a frame, keeping each frame glitch-free.
  always_comb begin
    if (cnt_q == LastCnt) begin
      cnt_d    = '0;
      active_d = d_q;
    end else begin
      cnt_d    = cnt_q + 8'd1;
      active_d = active_q;
    end
    clk_d = (cnt_q < active_q);
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      prev_q   <= '1;
      fill_q   <= '0;
      d_q      <= ResetVal;
      active_q <= ResetVal;
      cnt_q    <= '0;
      clk_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      fill_q   <= fill_d;
      d_q      <= d_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      clk_q    <= clk_d;
    end
  end

  function automatic logic [0:6] seg7(input logic [3:0] v);
    logic [0:6] s;
    case (v)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    ones = 4'(d_q % 8'd10);
    tens = 4'((d_q / 8'd10) % 8'd10);
    hund = 4'(d_q / 8'd100);
  end

  assign d0  = seg7(ones);
  assign d1  = seg7(tens);
  assign d2  = seg7(hund);
  assign d3  = 7'b1111111;
  assign d   = d_q;
  assign clk = clk_q;

endmodule

// File: tb/tb_clk_duty.sv
// Randomized and directed bench for clk_duty, checked cycle by cycle against a frame-level
// model of duty, PWM output and display.
module tb_clk_duty;

  localparam int P  = 100;
  localparam int RD = 50;

  logic       clkin = 1'b0;
  logic       reset;
  logic [3:0] btn_n;  // [0]=inc1 [1]=inc [2]=dec1 [3]=dec, active low
  logic       pwm;
  logic [0:6] d0, d1, d2, d3;
  logic [7:0] duty;

  always #5 clkin = ~clkin;

  clk_duty #(
    .PERIOD     (100),
    .RESET_DUTY (50),
    .STEP_FINE  (1),
    .STEP_COARSE(10)
  ) u_dut (
    .clkin(clkin),
    .reset(reset),
    .inc  (btn_n[1]),
    .inc1 (btn_n[0]),
    .dec  (btn_n[3]),
    .dec1 (btn_n[2]),
    .clk  (pwm),
    .d0   (d0),
    .d1   (d1),
    .d2   (d2),
    .d3   (d3),
    .d    (duty)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: edges counted since reset release
  int         n;
  int         m_d;
  int         m_act;
  bit         exp_clk;
  logic [3:0] last_s;
  int         pend_at[$];
  int         pend_step[$];

  function automatic int sat(input int v);
    return (v > P) ? P : ((v < 0) ? 0 : v);
  endfunction

  function automatic logic [6:0] enc(input int v);
    logic [6:0] tbl[10];
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    return (v >= 0 && v <= 9) ? tbl[v] : 7'b1111111;
  endfunction

  function automatic int exp_disp(input int v);
    return int'({enc(v / 100), enc((v / 10) % 10), enc(v % 10), 7'b1111111});
  endfunction

  task automatic model_reset();
    n       = 0;
    m_d     = RD;
    m_act   = RD;
    exp_clk = 1'b0;
    last_s  = '1;
    pend_at.delete();
    pend_step.delete();
  endtask

  always @(posedge clkin) begin
    int         pre_d;
    int         p;
    logic [3:0] nw;
    if (!reset) begin
      pre_d   = m_d;
      n++;
      p       = (n - 1) % P;
      exp_clk = (p < m_act);
      if (p == P - 1) m_act = pre_d;
      while (pend_at.size() > 0 && pend_at[0] == n) begin
        m_d = sat(m_d + pend_step[0]);
        void'(pend_at.pop_front());
        void'(pend_step.pop_front());
      end
      // A press is a high->low change between two real samples; it lands two edges later.
      if (n >= 2) begin
        nw = last_s & ~btn_n;
        if (nw != 4'b0000) begin
          pend_at.push_back(n + 2);
          if (nw[0])      pend_step.push_back(10);
          else if (nw[1]) pend_step.push_back(1);
          else if (nw[2]) pend_step.push_back(-10);
          else            pend_step.push_back(-1);
        end
      end
      last_s = btn_n;
    end
  end

  always @(negedge clkin) begin
    if (!reset && n >= 1) begin
      check("clk", int'(pwm), int'(exp_clk));
      check("d", int'(duty), m_d);
      check("disp", int'({d2, d1, d0, d3}), exp_disp(m_d));
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clkin);
    #1;
  endtask

  task automatic press(input logic [3:0] mask, input int lo, input int gap);
    btn_n = ~mask;
    tick(lo);
    btn_n = '1;
    tick(gap);
  endtask

  task automatic do_reset();
    @(negedge clkin);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("rst_clk", int'(pwm), 0);
    check("rst_d", int'(duty), RD);
    check("rst_disp", int'({d2, d1, d0, d3}), exp_disp(RD));
    @(negedge clkin);
    @(negedge clkin);
    reset = 1'b0;
  endtask

  task automatic count_high(input string tag, input int expv);
    int h = 0;
    repeat (P) begin
      @(negedge clkin);
      h += int'(pwm);
    end
    check(tag, h, expv);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset = 1'b1;
    btn_n = '1;
    model_reset();

    // 1: idle after reset
    do_reset();
    count_high("t1_high", 50);
    check("t1_d2", int'(d2), int'(7'b0000001));
    check("t1_d1", int'(d1), int'(7'b0100100));
    check("t1_d0", int'(d0), int'(7'b0000001));

    // 2: fourteen fine increments
    do_reset();
    tick(4);
    repeat (14) press(4'b0010, 3, 3);
    tick(2 * P + 7);
    check("t2_d", int'(duty), 64);
    check("t2_d1", int'(d1), int'(7'b0100000));
    check("t2_d0", int'(d0), int'(7'b1001100));
    count_high("t2_high", 64);

    // 3: coarse increments saturate at PERIOD
    do_reset();
    tick(4);
    repeat (6) press(4'b0001, 3, 3);
    tick(2 * P);
    check("t3_d", int'(duty), 100);
    count_high("t3_high", 100);

    // 4: decrements saturate at zero
    do_reset();
    tick(4);
    repeat (6) press(4'b0100, 2, 4);
    press(4'b1000, 2, 4);
    press(4'b1000, 2, 4);
    tick(2 * P);
    check("t4_d", int'(duty), 0);
    count_high("t4_high", 0);

    // 5: simultaneous inc and dec1, inc wins
    do_reset();
    tick(4);
    press(4'b0110, 2, 5);
    check("t5_d", int'(duty), 51);

    // 6: reset during the high phase of a 70% frame
    do_reset();
    tick(4);
    repeat (2) press(4'b0001, 3, 3);
    tick(P + 5);
    seen = 1'b0;
    for (int i = 0; i < 2 * P && !seen; i++) begin
      @(negedge clkin);
      if (pwm) seen = 1'b1;
    end
    check("t6_seen_high", int'(seen), 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("t6_rst_clk", int'(pwm), 0);
    check("t6_rst_d", int'(duty), RD);
    @(negedge clkin);
    reset = 1'b0;
    count_high("t6_high", 50);

    // Button held low across reset release is ignored until pressed again
    @(negedge clkin);
    #2 reset = 1'b1;
    btn_n = 4'b1101;
    #1;
    model_reset();
    @(negedge clkin);
    reset = 1'b0;
    tick(6);
    btn_n = '1;
    tick(4);
    check("held_d", int'(duty), RD);
    press(4'b0010, 2, 4);
    check("held_repress_d", int'(duty), RD + 1);

    // Random presses, including multi-button masks
    do_reset();
    tick(4);
    for (int i = 0; i < 60; i++) begin
      logic [3:0] mask;
      if ($urandom_range(0, 3) == 0) mask = 4'($urandom_range(1, 15));
      else                           mask = 4'(1 << $urandom_range(0, 3));
      press(mask, int'($urandom_range(2, 5)), int'($urandom_range(1, 6)));
      if ($urandom_range(0, 9) == 0) tick(int'($urandom_range(50, 150)));
    end
    tick(2 * P + 5);
    count_high("rand_high", m_d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
